// File: rtl/trap_entry_unit.sv
// Trap entry unit: takes syscall/interrupt traps at instruction boundaries, captures EPC/cause, redirects to the handler.
// Optional define TRAP_IRQ_SYNC_EN inserts a 2-flop synchronizer on every irq line.
module trap_entry_unit #(
  parameter int          IRQ_W        = 6,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IRQ_W-1:0] irq,
  input  logic             instr_valid,
  input  logic             syscall,
  input  logic [31:0]      pc_4,
  input  logic             eret,
  input  logic             mask_we,
  input  logic [IRQ_W-1:0] mask_wdata,
  output logic             trap_taken,
  output logic [31:0]      trap_pc,
  output logic [31:0]      epc,
  output logic [31:0]      cause,
  output logic             exl,
  output logic [IRQ_W-1:0] mask,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_HANDLER = 2'd2
  } state_e;

  state_e           state_q;
  logic             trap_taken_q;
  logic             exl_q;
  logic [31:0]      epc_q;
  logic [31:0]      cause_q;
  logic [IRQ_W-1:0] mask_q;

  logic [IRQ_W-1:0] irq_s;
  logic [IRQ_W-1:0] ip_d;
  logic [31:0]      epc_d;
  logic [31:0]      cause_d;
  logic             take_sys;
  logic             take_irq;

`ifdef TRAP_IRQ_SYNC_EN
  logic [IRQ_W-1:0] sync1_q;
  logic [IRQ_W-1:0] sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  // instr_valid marks a committing instruction: the only cycle a trap may be
  // taken. syscall and pc_4 are meaningful only while instr_valid is high.
  always_comb begin
    ip_d     = irq_s & mask_q;
    take_sys = instr_valid & syscall;
    take_irq = instr_valid & (|ip_d);
    epc_d    = take_sys ? (pc_4 - 32'd4) : pc_4;
    cause_d  = '0;
    cause_d[6:2]        = take_sys ? 5'd8 : 5'd0;
    cause_d[8 +: IRQ_W] = ip_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      trap_taken_q <= 1'b0;
      exl_q        <= 1'b0;
      epc_q        <= '0;
      cause_q      <= '0;
      mask_q       <= '0;
    end else begin
      // The trap decision this edge still sees the old mask_q.
      if (mask_we) mask_q <= mask_wdata;
      trap_taken_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_sys || take_irq) begin
            state_q      <= ST_ENTER;
            trap_taken_q <= 1'b1;
            epc_q        <= epc_d;
            cause_q      <= cause_d;
          end
        end
        ST_ENTER: begin
          state_q <= ST_HANDLER;
          exl_q   <= 1'b1;
        end
        ST_HANDLER: begin
          if (eret) begin
            state_q <= ST_IDLE;
            exl_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          exl_q   <= 1'b0;
        end
      endcase
    end
  end

  assign trap_taken = trap_taken_q;
  assign trap_pc    = HANDLER_ADDR;
  assign epc        = epc_q;
  assign cause      = cause_q;
  assign exl        = exl_q;
  assign mask       = mask_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/trap_entry_unit.md
# trap_entry_unit

Initiator side of the processor's trap protocol. It samples external interrupt lines and the syscall indication from the execute stage, and waits for an instruction boundary. It then captures EPC and cause and redirects the PC to the handler. The return half (`eret` restoring the PC from EPC) lives in the execute stage; this block only observes `eret` to leave handler mode. It sits beside the execute stage and feeds the PC-select mux and the coprocessor read path.

## Interface
- `IRQ_W`, default 6: number of external interrupt lines; legal range 1..8.
- `HANDLER_ADDR`, default 32'h0000_4180: fixed handler entry address.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `irq`  in  IRQ_W  level-sensitive interrupt requests.
- `instr_valid`  in  1  an instruction commits this cycle; the only point a trap may be taken.
- `syscall`  in  1  the committing instruction is SYSCALL; qualified by `instr_valid`.
- `pc_4`  in  32  PC+4 of the committing instruction.
- `eret`  in  1  ERET committed this cycle.
- `mask_we`  in  1  write interrupt mask.
- `mask_wdata`  in  IRQ_W  new mask value; 1 = enabled.
- `trap_taken`  out  1  one-cycle pulse; PC mux must select `trap_pc`.
- `trap_pc`  out  32  constant `HANDLER_ADDR`.
- `epc`  out  32  saved return address.
- `cause`  out  32  bits [6:2] exception code, bits [8+IRQ_W-1:8] pending-interrupt snapshot, all other bits 0.
- `exl`  out  1  1 while in handler mode.
- `mask`  out  IRQ_W  current interrupt mask.

## Operation
- States: IDLE, ENTER, HANDLER.
- `irq_s` is `irq`, or its synchronized version when the synchronizer is enabled (see Configuration).
- `pend` = |(`irq_s` & `mask`).
- IDLE, `instr_valid` & `syscall`:
  - go to ENTER.
  - `epc` <= `pc_4` − 4, modulo 2^32; 0 − 4 wraps to 32'hFFFF_FFFC.
  - `cause` exception code <= 8; IP field <= `irq_s` & `mask`.
- IDLE, else if `instr_valid` & `pend`:
  - go to ENTER.
  - `epc` <= `pc_4`.
  - `cause` exception code <= 0; IP field <= `irq_s` & `mask`.
- Syscall has priority over an interrupt on the same cycle.
- With `instr_valid` low, pending interrupts wait in IDLE; no state is captured.
- ENTER: `trap_taken` = 1, `exl` <= 1; unconditionally go to HANDLER next cycle.
- HANDLER:
  - `irq` and `syscall` are ignored; `epc` and `cause` hold.
  - `eret` moves to IDLE and clears `exl` at the same edge.
- `eret` in IDLE or ENTER is ignored.
- `mask_we` may be asserted in any state. The new mask takes effect the cycle after the write; the trap decision at that same edge uses the old mask.

## Timing
- Reset values:
  - state IDLE, `trap_taken` 0, `exl` 0.
  - `epc` 0, `cause` 0, `mask` all zeros (all interrupts disabled).
  - `trap_pc` is always `HANDLER_ADDR`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Trap decision at edge E (syscall or interrupt committed). `trap_taken` is high for exactly the cycle after E; `exl` rises at the edge that ends that cycle.
- `epc` and `cause` are valid in the same cycle `trap_taken` is high.
- Interrupt latency with the synchronizer disabled: `irq` high before edge E with `instr_valid` high at E gives `trap_taken` in cycle E+1. The synchronizer adds 2 cycles.
- `eret` in HANDLER at edge E: `exl` = 0 in cycle E+1. A still-pending interrupt can trap at the earliest on edge E+1, giving `trap_taken` in cycle E+2.
- `reset` overrides everything in any state, including mid-ENTER and mid-HANDLER; all registers return to reset values at that edge.

## Configuration
- `TRAP_IRQ_SYNC_EN` defined:
  - each `irq` bit passes through a 2-flop synchronizer reset to 0.
  - the trap decision uses the second stage, adding 2 cycles of latency.
  - the `cause` IP snapshot is taken from the synchronized value.
- `TRAP_IRQ_SYNC_EN` undefined: `irq` is used directly; it must already be synchronous to `clock`.

## Test plan
- Reset, then `mask` = 0, `irq` = 6'b000001, `instr_valid` high for 10 cycles -> no `trap_taken`; `exl` = 0; `cause` = 0.
- Write `mask` = 6'b111111, `irq` = 6'b000100, `instr_valid` with `pc_4` = 32'h0000_1008 -> one-cycle `trap_taken`; `epc` = 32'h0000_1008; `cause` = 32'h0000_0400; `exl` = 1.
- `syscall` and `irq[0]` on the same commit, `pc_4` = 32'h0000_2004 -> `epc` = 32'h0000_2000; `cause` = 32'h0000_0120.
- In HANDLER, toggle `irq` and pulse `syscall` -> no further `trap_taken`; `epc` and `cause` unchanged. Then pulse `eret` with `irq[1]` still high -> `exl` = 0 next cycle, a new `trap_taken` one cycle later.
- `syscall` with `pc_4` = 0 -> `epc` = 32'hFFFF_FFFC. Assert `reset` during HANDLER -> all outputs return to reset values at that edge.
- With `TRAP_IRQ_SYNC_EN`, `irq[3]` rising while `instr_valid` is held high -> `trap_taken` exactly 2 cycles later than in the unsynchronized build.
